spi_master_cfg: RTL and testbench
=================================

// Module: spi_master_cfg
//
// PURPOSE
// Parametrised SPI master: full-duplex transfer of one DATA_W-bit word per start request.
// Provides programmable SCL rate, SPI mode (CPOL/CPHA) and SS lead/lag timing.
// Uses a start/busy/done handshake so on-chip test sequencers can issue repeated
// transfers to external slaves, e.g. ADCs or DUT monitors on the 50 MHz board.
//
// PARAMETERS
// DATA_W   8    bits per transfer (>=1)
// CLK_DIV  100  clk cycles per SCL half-period (>=2); default gives 250 kHz SCL
// CPOL     0    SCL idle level
// CPHA     1    0: sample MISO on leading edge; 1: sample MISO on trailing edge
// SS_LEAD  1    SCL half-periods from SS falling to the first SCL edge (>=1)
// SS_LAG   1    SCL half-periods from the last SCL edge to SS rising (>=1)
//
// PORTS
// clk      in   1       system clock (50 MHz)
// rst      in   1       asynchronous reset, active-low
// start    in   1       request a transfer; accepted only while busy=0
// tx_data  in   DATA_W  word to send; latched in the cycle start is accepted
// busy     out  1       transfer in progress (LEAD..GAP)
// done     out  1       one-cycle pulse when the transfer completes
// rx_data  out  DATA_W  received word; updated in the done cycle, then held
// SCL      out  1       serial clock
// SS       out  1       slave select, active-low
// MOSI     out  1       master out
// MISO     in   1       master in; synchronous to SCL, not resynchronised
//
// BEHAVIOUR
// - Reset values: SCL=CPOL, SS=1, MOSI=0, busy=0, done=0, rx_data=0, state=IDLE.
// - Half-period tick: counter 0..CLK_DIV-1, width $clog2(CLK_DIV). Runs only outside IDLE.
//   The counter clears on entry to LEAD. tick = (cnt==CLK_DIV-1).
// - FSM: IDLE -> LEAD (SS_LEAD ticks) -> XFER (2*DATA_W ticks) -> LAG (SS_LAG ticks)
//   -> GAP (1 tick) -> IDLE.
// - IDLE + start: latch tx_data into the shift register. Next cycle: busy=1, SS=0, state=LEAD.
// - CPHA=0: drive the first bit on MOSI at LEAD entry.
//   - Leading SCL edge: sample MISO.
//   - Trailing edge: shift the next bit onto MOSI.
// - CPHA=1: MOSI is 0 during LEAD.
//   - Leading SCL edge: drive the next bit.
//   - Trailing edge: sample MISO.
// - XFER: SCL toggles on each tick; there are exactly 2*DATA_W edges.
//   SCL ends at CPOL and stays there through LAG, GAP and IDLE.
// - Bit order: MSB first. Edge counter width is $clog2(2*DATA_W+1).
// - LAG: MOSI=0. SS rises on the final LAG tick.
// - GAP: SS stays high for CLK_DIV cycles, which guarantees minimum deselect time.
// - GAP end: done=1 for one cycle, rx_data<=shift-in register, busy=0, state=IDLE (same cycle).
//   A start in the cycle after done is accepted.
// - Busy high for exactly (SS_LEAD+2*DATA_W+SS_LAG+1)*CLK_DIV cycles.
// - start while busy=1: ignored, not queued. tx_data changes after acceptance: no effect.
// - rst asserted mid-transfer: immediate return to reset values. No done, rx_data cleared.
//
// CONFIGURATION
// SPI_LSB_FIRST_EN defined: shift out tx_data[0] first; MISO assembled LSB first.
//   rx_data[0] = first bit received.
// Not defined: MSB first; tx_data[DATA_W-1] is sent first; rx_data[DATA_W-1] = first bit received.
// Timing, handshake and FSM are identical in both builds.
//
// TESTING
// 1. Defaults, MOSI looped to MISO, start with tx=8'hAA -> SCL period 200 clk.
//    8 falling edges with SS low; MOSI bits 1,0,1,0... sampled on falling edge.
//    rx_data=8'hAA, single done pulse, busy high 1900 cycles.
// 2. All 4 CPOL/CPHA combos with a behavioural mode-matched slave.
//    Master sends tx=8'h3C; slave returns 8'hC5.
//    -> slave receives 3C, rx_data=C5, idle SCL==CPOL before and after.
// 3. start pulsed at mid-XFER, and tx_data changed while busy
//    -> no second transfer, transmitted word unchanged.
//    Back-to-back start in the cycle after done is accepted.
// 4. DATA_W=16, CLK_DIV=2, tx=16'hBEEF, slave returns 16'h1234
//    -> rx_data=16'h1234, busy exactly 70 cycles, SS high >= 2 cycles between transfers.
// 5. rst low after the 4th SCL edge -> SCL=CPOL, SS=1, MOSI=0, busy=0 asynchronously.
//    No done. Next transfer of 8'h5A completes correctly.
// 6. Build with SPI_LSB_FIRST_EN, tx=8'h01, loopback
//    -> first MOSI bit 1, remaining bits 0, rx_data=8'h01.

Source files
------------

// File: rtl/spi_master_cfg_if.sv
// ---------------------------------------------------------------------------
// spi_master_cfg_if
// Bundle of the transfer handshake and SPI pin signals for spi_master_cfg.
//
// Signals
//   start    request a transfer (sequencer -> master)
//   tx_data  word to send, DATA_W bits (sequencer -> master)
//   busy     transfer in progress (master -> sequencer)
//   done     one-cycle completion pulse (master -> sequencer)
//   rx_data  received word, DATA_W bits (master -> sequencer)
//   SCL      serial clock (master -> slave)
//   SS       slave select, active-low (master -> slave)
//   MOSI     master out (master -> slave)
//   MISO     master in (slave -> master)
//
// Modports
//   master   view taken by the SPI master block
//   slave    view taken by whatever drives start/tx_data/MISO
// ---------------------------------------------------------------------------
interface spi_master_cfg_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              SCL;
    logic              SS;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  start,
        input  tx_data,
        input  MISO,
        output busy,
        output done,
        output rx_data,
        output SCL,
        output SS,
        output MOSI
    );

    modport slave (
        output start,
        output tx_data,
        output MISO,
        input  busy,
        input  done,
        input  rx_data,
        input  SCL,
        input  SS,
        input  MOSI
    );
endinterface

// File: rtl/spi_master_cfg.sv
// ---------------------------------------------------------------------------
// spi_master_cfg
// SPI master moving one DATA_W-bit word full-duplex per accepted start
// request, with programmable SCL rate, CPOL/CPHA mode and SS lead/lag
// timing. A start/busy/done handshake lets an on-chip sequencer issue
// repeated transfers.
//
// Ports
//   clk   in  system clock
//   rst   in  asynchronous reset, active-low
//   bus   spi_master_cfg_if.master:
//         start/tx_data in, busy/done/rx_data out,
//         SCL/SS/MOSI out, MISO in (MISO is used directly, not resynchronised;
//         it is synchronous to SCL, which this block generates)
//
// Parameters
//   DATA_W   bits per transfer (>=1)
//   CLK_DIV  clk cycles per SCL half-period (>=2)
//   CPOL     SCL idle level
//   CPHA     0: sample on leading edge, 1: sample on trailing edge
//   SS_LEAD  half-periods of SS-low lead-in before XFER (>=1)
//   SS_LAG   half-periods from the last SCL edge to SS rising (>=1)
//
// Build option
//   SPI_LSB_FIRST_EN  when defined, tx_data[0] is shifted out first and the
//                     first received bit lands in rx_data[0]. Otherwise the
//                     transfer is MSB first. Timing is the same in both.
//
// State table
//   state  | meaning
//   S_IDLE | waiting for start, SS high, SCL at CPOL, half-period timer held
//   S_LEAD | SS low, SCL idle, SS_LEAD half-periods before the first edge
//   S_XFER | SCL toggles on every half-period tick, 2*DATA_W edges in total
//   S_LAG  | SCL back at CPOL, MOSI low, SS rises on the last LAG tick
//   S_GAP  | SS high for one half-period of minimum deselect, then done
// ---------------------------------------------------------------------------
module spi_master_cfg #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 100,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b1,
    parameter int SS_LEAD = 1,
    parameter int SS_LAG  = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_cfg_if.master bus
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam int PH_MAX = (SS_LEAD > SS_LAG) ? SS_LEAD : SS_LAG;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic [PH_W-1:0]   LEAD_LAST = PH_W'(SS_LEAD - 1);
    localparam logic [PH_W-1:0]   LAG_LAST  = PH_W'(SS_LAG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_LAG,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [EDGE_W-1:0]   r_edge;
    logic [PH_W-1:0]     r_ph;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]   r_rx_sr;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_scl;
    logic                r_ss;
    logic                r_mosi;
    logic                r_busy;
    logic                r_done;

    logic                w_tick;
    logic                w_leading;
    logic                w_last_edge;
    logic                w_sample_edge;

    // Bit-order helpers: the only place the two builds differ.
    function automatic logic f_first(input logic [DATA_W-1:0] v);
`ifdef SPI_LSB_FIRST_EN
        return v[0];
`else
        return v[DATA_W-1];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] f_shift_out(input logic [DATA_W-1:0] v);
`ifdef SPI_LSB_FIRST_EN
        return v >> 1;
`else
        return v << 1;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] f_shift_in(input logic [DATA_W-1:0] v,
                                                     input logic              b);
        logic [DATA_W-1:0] res;
`ifdef SPI_LSB_FIRST_EN
        res             = v >> 1;
        res[DATA_W-1]   = b;
`else
        res             = v << 1;
        res[0]          = b;
`endif
        return res;
    endfunction

    assign w_tick        = (r_cnt == CNT_LAST);
    // Edges are numbered from zero, so even-numbered edges leave CPOL.
    assign w_leading     = ~r_edge[0];
    assign w_last_edge   = (r_edge == EDGE_LAST);
    assign w_sample_edge = (w_leading == !CPHA);

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.SCL     = r_scl;
    assign bus.SS      = r_ss;
    assign bus.MOSI    = r_mosi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_ph      <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_scl     <= CPOL;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Half-period timer is held at zero in IDLE so it starts clean
            // on LEAD entry.
            if (r_state == S_IDLE || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LEAD;
                        r_busy  <= 1'b1;
                        r_ss    <= 1'b0;
                        r_ph    <= '0;
                        r_edge  <= '0;
                        r_rx_sr <= '0;
                        if (!CPHA) begin
                            // Mode 0/2: first bit must be valid before the
                            // leading edge samples it.
                            r_mosi  <= f_first(bus.tx_data);
                            r_tx_sr <= f_shift_out(bus.tx_data);
                        end else begin
                            r_mosi  <= 1'b0;
                            r_tx_sr <= bus.tx_data;
                        end
                    end
                end

                S_LEAD: begin
                    if (w_tick) begin
                        if (r_ph == LEAD_LAST) begin
                            r_state <= S_XFER;
                            r_ph    <= '0;
                        end else begin
                            r_ph <= r_ph + 1'b1;
                        end
                    end
                end

                S_XFER: begin
                    if (w_tick) begin
                        r_scl  <= ~r_scl;
                        r_edge <= r_edge + 1'b1;
                        if (w_sample_edge) begin
                            r_rx_sr <= f_shift_in(r_rx_sr, bus.MISO);
                        end else if (!w_last_edge) begin
                            // CPHA=0 drives on trailing edges, CPHA=1 on
                            // leading; the final edge never drives a bit.
                            r_mosi  <= f_first(r_tx_sr);
                            r_tx_sr <= f_shift_out(r_tx_sr);
                        end
                        if (w_last_edge) begin
                            r_state <= S_LAG;
                            r_mosi  <= 1'b0;
                        end
                    end
                end

                S_LAG: begin
                    if (w_tick) begin
                        if (r_ph == LAG_LAST) begin
                            r_ss    <= 1'b1;
                            r_state <= S_GAP;
                            r_ph    <= '0;
                        end else begin
                            r_ph <= r_ph + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (w_tick) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_rx_data <= r_rx_sr;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
`timescale 1ns/1ps
module tb_spi_master_cfg;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Default-parameter master with MOSI looped back to MISO.
    spi_master_cfg_if #(.DATA_W(8)) bus0 ();
    spi_master_cfg #(.DATA_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    assign bus0.MISO = bus0.MOSI;

    // Configs 0..3: CLK_DIV=4, mode {CPOL,CPHA} = g. Config 4: DATA_W=16, CLK_DIV=2.
    logic [4:0]  cf_start;
    logic [4:0]  cf_busy, cf_done, cf_scl, cf_ss;
    logic [15:0] cf_rx  [5];
    logic [15:0] cf_srx [5];

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int          W      = (g == 4) ? 16 : 8;
        localparam bit          P_CPOL = (g == 2 || g == 3);
        localparam bit          P_CPHA = (g == 1 || g == 3 || g == 4);
        localparam int          P_DIV  = (g == 4) ? 2 : 4;
        localparam logic [15:0] TX_W   = (g == 4) ? 16'hBEEF : 16'h003C;
        localparam logic [15:0] SL_W   = (g == 4) ? 16'h1234 : 16'h00C5;

        spi_master_cfg_if #(.DATA_W(W)) bus ();
        spi_master_cfg #(.DATA_W(W), .CLK_DIV(P_DIV), .CPOL(P_CPOL), .CPHA(P_CPHA))
            u_dut (.clk(clk), .rst(rst), .bus(bus));

        logic [W-1:0] s_tx, s_rx;
        logic         mosi_q, prev_ss, prev_scl;

        assign bus.start   = cf_start[g];
        assign bus.tx_data = W'(TX_W);
        assign cf_busy[g]  = bus.busy;
        assign cf_done[g]  = bus.done;
        assign cf_scl[g]   = bus.SCL;
        assign cf_ss[g]    = bus.SS;
        assign cf_rx[g]    = 16'(bus.rx_data);
        assign cf_srx[g]   = 16'(s_rx);

        // MOSI as it was before the current SCL edge.
        always @(negedge clk) mosi_q = bus.MOSI;

        // Behavioural mode-matched slave.
        always @(bus.SS, bus.SCL) begin
            if (prev_ss === 1'b1 && bus.SS === 1'b0) begin
                s_tx = W'(SL_W);
                s_rx = '0;
                if (!P_CPHA) begin
`ifdef SPI_LSB_FIRST_EN
                    bus.MISO = s_tx[0];
                    s_tx     = s_tx >> 1;
`else
                    bus.MISO = s_tx[W-1];
                    s_tx     = s_tx << 1;
`endif
                end else begin
                    bus.MISO = 1'b0;
                end
            end else if (bus.SS === 1'b0 && bus.SCL !== prev_scl) begin
                if ((bus.SCL !== P_CPOL) == !P_CPHA) begin
`ifdef SPI_LSB_FIRST_EN
                    s_rx = {mosi_q, s_rx[W-1:1]};
`else
                    s_rx = {s_rx[W-2:0], mosi_q};
`endif
                end else begin
`ifdef SPI_LSB_FIRST_EN
                    bus.MISO = s_tx[0];
                    s_tx     = s_tx >> 1;
`else
                    bus.MISO = s_tx[W-1];
                    s_tx     = s_tx << 1;
`endif
                end
            end
            prev_ss  = bus.SS;
            prev_scl = bus.SCL;
        end
    end

    // Order in which bits of v appear on the wire, first bit in [7].
    function automatic logic [7:0] wire_order(input logic [7:0] v);
`ifdef SPI_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int         m_busy, m_done, m_fall;
    logic [7:0] m_bits;
    bit         m_to;

    // Runs one transfer on bus0, starting at the current negedge.
    task automatic xfer0(input logic [7:0] tx, input bit mid_poke);
        logic p_scl, p_mosi;
        m_busy = 0; m_done = 0; m_fall = 0; m_bits = '0; m_to = 1'b1;
        bus0.tx_data = tx;
        bus0.start   = 1'b1;
        p_scl  = bus0.SCL;
        p_mosi = bus0.MOSI;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n == 0) bus0.start = 1'b0;
            if (mid_poke && n == 900) begin bus0.start = 1'b1; bus0.tx_data = 8'hFF; end
            if (mid_poke && n == 901) bus0.start = 1'b0;
            if (bus0.busy) m_busy++;
            if (bus0.done) m_done++;
            if (p_scl && !bus0.SCL && !bus0.SS) begin
                m_fall++;
                m_bits = {m_bits[6:0], p_mosi};
            end
            p_scl  = bus0.SCL;
            p_mosi = bus0.MOSI;
            if (bus0.done) begin m_to = 1'b0; break; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bcnt [5];
        int  dcnt [5];
        int  ss_gap, edges, late_done;
        bit  seen_low, gap_done, all_done;
        logic p_scl;

        rst = 1'b0;
        bus0.start = 1'b0;
        bus0.tx_data = '0;
        cf_start = '0;
        repeat (3) @(negedge clk);

        chk("rst_scl",  bus0.SCL, 0);
        chk("rst_ss",   bus0.SS, 1);
        chk("rst_mosi", bus0.MOSI, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_rx",   bus0.rx_data, 0);
        chk("rst_cf_scl", cf_scl, 5'b01100);
        chk("rst_cf_ss",  cf_ss, 5'b11111);

        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic loopback, default parameters.
        xfer0(8'hAA, 1'b0);
        chk("t1_timeout", m_to, 0);
        chk("t1_rx",      bus0.rx_data, 8'hAA);
        chk("t1_busy",    m_busy, 1900);
        chk("t1_done",    m_done, 1);
        chk("t1_falls",   m_fall, 8);
        chk("t1_bits",    m_bits, wire_order(8'hAA));
        @(negedge clk);
        chk("t1_done_pulse", bus0.done, 0);
        chk("t1_scl_idle",   bus0.SCL, 0);

        // start/tx_data poked mid-transfer, started in the cycle after done.
        xfer0(8'h96, 1'b1);
        chk("t3_timeout", m_to, 0);
        chk("t3_rx",      bus0.rx_data, 8'h96);
        chk("t3_bits",    m_bits, wire_order(8'h96));
        chk("t3_busy",    m_busy, 1900);
        chk("t3_done",    m_done, 1);
        @(negedge clk);
        chk("t3_not_queued", bus0.busy, 0);
        xfer0(8'h3C, 1'b0);
        chk("t3_b2b_busy", m_busy, 1900);
        chk("t3_b2b_rx",   bus0.rx_data, 8'h3C);

        // Single set bit: shows which end leaves first.
        @(negedge clk);
        xfer0(8'h01, 1'b0);
        chk("t6_rx",   bus0.rx_data, 8'h01);
        chk("t6_bits", m_bits, wire_order(8'h01));
`ifdef SPI_LSB_FIRST_EN
        chk("t6_first", m_bits[7], 1);
`else
        chk("t6_first", m_bits[7], 0);
`endif

        // All modes and the 16-bit fast config, in parallel.
        for (int k = 0; k < 5; k++) begin bcnt[k] = 0; dcnt[k] = 0; end
        ss_gap = 0; seen_low = 1'b0; gap_done = 1'b0; all_done = 1'b0;
        @(negedge clk) cf_start = 5'b11111;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (n == 0) cf_start = '0;
            for (int k = 0; k < 5; k++) begin
                if (cf_busy[k] && dcnt[k] == 0) bcnt[k]++;
                if (cf_done[k]) dcnt[k]++;
            end
            cf_start[4] = (cf_done[4] && dcnt[4] == 1);
            if (!cf_ss[4]) begin
                if (ss_gap > 0) gap_done = 1'b1;
                seen_low = 1'b1;
            end else if (seen_low && !gap_done) begin
                ss_gap++;
            end
            if (dcnt[0] >= 1 && dcnt[1] >= 1 && dcnt[2] >= 1 && dcnt[3] >= 1 && dcnt[4] >= 2) begin
                all_done = 1'b1;
                break;
            end
        end
        cf_start = '0;
        chk("t2_all_done", all_done, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_rx_m%0d", k),    cf_rx[k],  16'h00C5);
            chk($sformatf("t2_slave_m%0d", k), cf_srx[k], 16'h003C);
            chk($sformatf("t2_busy_m%0d", k),  bcnt[k],   76);
            chk($sformatf("t2_done_m%0d", k),  dcnt[k],   1);
        end
        repeat (3) @(negedge clk);
        chk("t2_scl_idle", cf_scl, 5'b01100);
        chk("t4_rx",    cf_rx[4],  16'h1234);
        chk("t4_slave", cf_srx[4], 16'hBEEF);
        chk("t4_busy",  bcnt[4],   70);
        checks++;
        assert (ss_gap >= 2) else begin
            failures++;
            $error("FAIL t4_ss_gap observed=%0d expected>=2", ss_gap);
        end

        // Reset in the middle of XFER.
        @(negedge clk);
        bus0.tx_data = 8'hF0;
        bus0.start   = 1'b1;
        edges = 0;
        p_scl = bus0.SCL;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n == 0) bus0.start = 1'b0;
            if (bus0.SCL !== p_scl) edges++;
            p_scl = bus0.SCL;
            if (edges == 4) break;
        end
        chk("t5_edges", edges, 4);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_scl",  bus0.SCL, 0);
        chk("t5_ss",   bus0.SS, 1);
        chk("t5_mosi", bus0.MOSI, 0);
        chk("t5_busy", bus0.busy, 0);
        chk("t5_rx",   bus0.rx_data, 0);
        @(negedge clk) rst = 1'b1;
        late_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.done) late_done++;
        end
        chk("t5_no_done", late_done, 0);
        xfer0(8'h5A, 1'b0);
        chk("t5_timeout", m_to, 0);
        chk("t5_rx_after", bus0.rx_data, 8'h5A);
        chk("t5_bits",     m_bits, wire_order(8'h5A));
        chk("t5_busy_after", m_busy, 1900);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
